// File: rtl/axis_reg_slice.sv
// AXI4-Stream register slice: an output register plus a skid register, so that
// tvalid, payload and tready all leave the block straight from flops.
module axis_reg_slice #(
  parameter int unsigned N         = 4,
  parameter int unsigned I         = 1,
  parameter int unsigned D         = 1,
  parameter int unsigned U         = 1,
  parameter bit          USE_TSTRB = 1'b0,
  parameter bit          USE_TKEEP = 1'b0
) (
  input  logic           aclk,
  input  logic           aresetn,

  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [8*N-1:0] s_tdata,
  input  logic [N-1:0]   s_tstrb,
  input  logic [N-1:0]   s_tkeep,
  input  logic           s_tlast,
  input  logic [I-1:0]   s_tid,
  input  logic [D-1:0]   s_tdest,
  input  logic [U-1:0]   s_tuser,

  output logic           m_tvalid,
  input  logic           m_tready,
  output logic [8*N-1:0] m_tdata,
  output logic [N-1:0]   m_tstrb,
  output logic [N-1:0]   m_tkeep,
  output logic           m_tlast,
  output logic [I-1:0]   m_tid,
  output logic [D-1:0]   m_tdest,
  output logic [U-1:0]   m_tuser
);

  localparam int unsigned PW = 8*N + 2*N + 1 + I + D + U;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e        state_q;
  logic          m_tvalid_q;
  logic          s_tready_q;
  logic [PW-1:0] out_q;
  logic [PW-1:0] skid_q;

  logic [N-1:0]  strb_in;
  logic [N-1:0]  keep_in;
  logic [PW-1:0] in_pl;
  logic          accept;
  logic          consume;
  logic          load_out;
  logic          load_skid;
  logic          out_from_skid;

  // Disabled strobe/keep lanes are forced to ones before storage, so the
  // m_ side needs no extra muxing.
  assign strb_in = USE_TSTRB ? s_tstrb : '1;
  assign keep_in = USE_TKEEP ? s_tkeep : '1;
  assign in_pl   = {s_tdata, strb_in, keep_in, s_tlast, s_tid, s_tdest, s_tuser};

  assign accept  = s_tvalid & s_tready_q;
  assign consume = m_tvalid_q & m_tready;

  // Control FSM: state plus the two handshake outputs, all registered.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= EMPTY;
      m_tvalid_q <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          s_tready_q <= 1'b1;
          if (accept) begin
            state_q    <= ONE;
            m_tvalid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            state_q    <= TWO;
            s_tready_q <= 1'b0;
          end else if (consume && !accept) begin
            state_q    <= EMPTY;
            m_tvalid_q <= 1'b0;
          end
        end
        TWO: begin
          if (consume) begin
            state_q    <= ONE;
            s_tready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          m_tvalid_q <= 1'b0;
          s_tready_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath load enables decoded from the same events the FSM sees.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: load_out = accept;
      ONE: begin
        load_out  = accept & consume;
        load_skid = accept & ~consume;
      end
      TWO: begin
        load_out      = consume;
        out_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: payload registers carry no reset; m_tvalid qualifies them, so a
  // reset here would only add fan-out on aresetn.
  always_ff @(posedge aclk) begin
    if (load_out) begin
      out_q <= out_from_skid ? skid_q : in_pl;
    end
    if (load_skid) begin
      skid_q <= in_pl;
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_q;

endmodule

// File: tb/tb_axis_reg_slice.sv
// Bench for axis_reg_slice: directed and random traffic compared each cycle
// against a queue model holding the beats the slice should currently own.
module tb_axis_reg_slice;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [1:0]  dest;
    logic [2:0]  user;
  } beat_t;

  logic        aclk;
  logic        aresetn;
  logic        s_tvalid;
  logic        s_tready;
  logic        m_tvalid;
  logic        m_tready;
  beat_t       drv;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [3:0]  m_tid;
  logic [1:0]  m_tdest;
  logic [2:0]  m_tuser;

  int    total = 0;
  int    bad   = 0;
  int    n_acc = 0;
  beat_t q[$];
  logic  mdl_ready = 1'b0;

  axis_reg_slice #(
    .N(4), .I(4), .D(2), .U(3), .USE_TSTRB(1'b1), .USE_TKEEP(1'b0)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (drv.data),
    .s_tstrb  (drv.strb),
    .s_tkeep  (drv.keep),
    .s_tlast  (drv.last),
    .s_tid    (drv.id),
    .s_tdest  (drv.dest),
    .s_tuser  (drv.user),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tstrb  (m_tstrb),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tdest  (m_tdest),
    .m_tuser  (m_tuser)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t m_beat();
    beat_t b;
    b = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = $urandom();
    b.strb = 4'($urandom_range(15));
    b.keep = 4'($urandom_range(15));
    b.last = 1'($urandom_range(1));
    b.id   = 4'($urandom_range(15));
    b.dest = 2'($urandom_range(3));
    b.user = 3'($urandom_range(7));
    return b;
  endfunction

  // Keep lanes are disabled on this instance, so the slice must emit all ones.
  function automatic beat_t expect_of(input beat_t b);
    beat_t e;
    e      = b;
    e.keep = 4'hF;
    return e;
  endfunction

  // One clock: drive inputs, let the edge happen, update the model and compare.
  // The slice holds at most two beats and is ready whenever it holds fewer.
  task automatic cycle(input logic rst_n, input logic v, input logic r, input beat_t b);
    beat_t pre;
    logic  acc;
    logic  con;
    logic  stalled;
    aresetn  = rst_n;
    s_tvalid = v;
    m_tready = r;
    drv      = b;
    acc      = v && mdl_ready;
    con      = (q.size() > 0) && r;
    stalled  = (q.size() > 0) && !r;
    pre      = m_beat();
    @(posedge aclk);
    #1;
    if (!rst_n) begin
      q.delete();
      mdl_ready = 1'b0;
    end else begin
      if (con) void'(q.pop_front());
      if (acc) begin
        q.push_back(expect_of(b));
        n_acc++;
      end
      mdl_ready = (q.size() < 2);
    end
    check("m_tvalid", 64'(m_tvalid), 64'(q.size() > 0));
    check("s_tready", 64'(s_tready), 64'(mdl_ready));
    if (q.size() > 0) check("payload", 64'(m_beat()), 64'(q[0]));
    if (stalled && rst_n) check("stall_hold", 64'(m_beat()), 64'(pre));
  endtask

  initial begin
    beat_t b;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    drv      = '0;

    // Reset for three cycles with traffic offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, rand_beat());
    cycle(1'b1, 1'b0, 1'b1, rand_beat());
    check("ready_after_reset", 64'(s_tready), 64'd1);

    // Single beat.
    b      = '0;
    b.data = 32'hA5A5_0001;
    b.last = 1'b1;
    b.id   = 4'd1;
    cycle(1'b1, 1'b1, 1'b1, b);
    check("single_data", 64'(m_tdata), 64'hA5A5_0001);
    check("single_keep", 64'(m_tkeep), 64'hF);
    cycle(1'b1, 1'b0, 1'b1, rand_beat());
    check("single_gone", 64'(m_tvalid), 64'd0);

    // Streaming 0..15 with the sink always ready.
    for (int i = 0; i < 16; i++) begin
      b      = rand_beat();
      b.data = 32'(i);
      cycle(1'b1, 1'b1, 1'b1, b);
      check("stream_data", 64'(m_tdata), 64'(i));
    end
    cycle(1'b1, 1'b0, 1'b1, rand_beat());

    // Backpressure: beats 0,1 fill both registers, beat 2 waits for space.
    for (int i = 0; i < 3; i++) begin
      b      = rand_beat();
      b.data = 32'(i);
      b.keep = 4'h0;
      cycle(1'b1, 1'b1, 1'b0, b);
      check("bp_hold_data", 64'(m_tdata), 64'd0);
    end
    check("bp_full_ready", 64'(s_tready), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, s_tready ? 1'b0 : 1'b1, 1'b1, b);
    check("bp_drained", 64'(m_tvalid), 64'd0);

    // Random stress at 50% valid / 50% ready.
    n_acc = 0;
    for (int c = 0; c < 20000 && n_acc < 1000; c++)
      cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), rand_beat());
    check("stress_accepted", 64'(n_acc), 64'd1000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, rand_beat());

    // Reset while both registers are full; no stale beat may reappear.
    cycle(1'b1, 1'b1, 1'b0, rand_beat());
    cycle(1'b1, 1'b1, 1'b0, rand_beat());
    check("two_full", 64'(s_tready), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, rand_beat());
    check("rst_two_valid", 64'(m_tvalid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1, rand_beat());
      check("no_stale", 64'(m_tvalid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
